// File: rtl/sm_ctrl.sv
// sm_ctrl: control and scheduling block for four PIO state machines that
// share one instruction memory. Holds the host-visible control registers
// (enables, restart strobes, fractional clock dividers, wrap bounds, forced
// instruction injection) and decides each cycle which state machines step.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   wr_en        host register write strobe
//   addr         register address
//   wdata        host write data
//   rdata        host read data, combinational from addr
//   sm_step      per-SM step enable
//   sm_restart   per-SM one-cycle soft restart
//   exec_valid   forced instruction pending, per SM
//   exec_instr   forced instruction, SM n at [INSTR_W*n +: INSTR_W]
//   wrap_top     per-SM wrap top, SM n at [PC_W*n +: PC_W]
//   wrap_bottom  per-SM wrap bottom, same packing
module sm_ctrl #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [4:0]           addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    output logic [3:0]           sm_step,
    output logic [3:0]           sm_restart,
    output logic [3:0]           exec_valid,
    output logic [4*INSTR_W-1:0] exec_instr,
    output logic [4*PC_W-1:0]    wrap_top,
    output logic [4*PC_W-1:0]    wrap_bottom
);

    // Register kind within a per-SM block: addr = 4 + 4n + k
    typedef enum logic [1:0] {
        REG_CLKDIV   = 2'd0,
        REG_EXECCTRL = 2'd1,
        REG_INSTR    = 2'd2,
        REG_NONE     = 2'd3
    } reg_kind_e;

    logic [3:0]         enable;
    logic [3:0]         restart_q;
    logic [3:0]         pending;
    logic [15:0]        div_int   [4];
    logic [7:0]         div_frac  [4];
    logic [PC_W-1:0]    wrap_bot_r[4];
    logic [PC_W-1:0]    wrap_top_r[4];
    logic [INSTR_W-1:0] instr_r   [4];
    logic [16:0]        cnt       [4];
    logic [7:0]         acc       [4];

    // Address decode
    logic      ctrl_sel;
    logic      blk_hit;
    logic [1:0] sm_idx;
    reg_kind_e kind;
    logic      ctrl_wr;

    always_comb begin
        ctrl_sel = (addr == 5'd0);
        blk_hit  = (addr[4:2] >= 3'd1) && (addr[4:2] <= 3'd4);
        sm_idx   = 2'(addr[4:2] - 3'd1);
        kind     = reg_kind_e'(addr[1:0]);
        ctrl_wr  = wr_en && ctrl_sel;
    end

    // Divider reload: {carry,acc} = acc + frac; reload = int_eff - 1 + carry,
    // with int==0 standing for 65536.
    logic [8:0]  acc_sum [4];
    logic [16:0] reload  [4];

    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            acc_sum[n] = {1'b0, acc[n]} + {1'b0, div_frac[n]};
            reload[n]  = ((div_int[n] == 16'd0) ? 17'h10000 : {1'b0, div_int[n]})
                         - 17'd1 + 17'(acc_sum[n][8]);
        end
    end

    // Step decode straight from flops
    always_comb begin
        for (int unsigned n = 0; n < 4; n++) begin
            sm_step[n] = enable[n] && (cnt[n] == 17'd0) && !restart_q[n];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable    <= '0;
            restart_q <= '0;
            pending   <= '0;
            for (int unsigned n = 0; n < 4; n++) begin
                div_int[n]    <= 16'd1;
                div_frac[n]   <= '0;
                wrap_bot_r[n] <= '0;
                wrap_top_r[n] <= '1;
                instr_r[n]    <= '0;
                cnt[n]        <= '0;
                acc[n]        <= '0;
            end
        end else begin
            // Restart strobe is registered from the write and self-clears
            restart_q <= ctrl_wr ? wdata[7:4] : 4'b0000;
            if (ctrl_wr) begin
                enable <= wdata[3:0];
            end
            for (int unsigned n = 0; n < 4; n++) begin
                if (wr_en && blk_hit && (sm_idx == 2'(n))) begin
                    case (kind)
                        REG_CLKDIV: begin
                            div_int[n]  <= wdata[31:16];
                            div_frac[n] <= wdata[15:8];
                        end
                        REG_EXECCTRL: begin
                            wrap_bot_r[n] <= wdata[PC_W-1:0];
                            wrap_top_r[n] <= wdata[8 +: PC_W];
                        end
                        default: ;
                    endcase
                end

                // A write landing in a step cycle stays pending (write wins)
                if (wr_en && blk_hit && (sm_idx == 2'(n)) && (kind == REG_INSTR)) begin
                    instr_r[n] <= wdata[INSTR_W-1:0];
                    pending[n] <= 1'b1;
                end else if ((ctrl_wr && wdata[4+n]) || sm_step[n]) begin
                    pending[n] <= 1'b0;
                end

                // Divider keeps running through a restart cycle; only the
                // step output is masked there.
                if (ctrl_wr && wdata[8+n]) begin
                    cnt[n] <= '0;
                    acc[n] <= '0;
                end else if (enable[n]) begin
                    if (cnt[n] == 17'd0) begin
                        acc[n] <= acc_sum[n][7:0];
                        cnt[n] <= reload[n];
                    end else begin
                        cnt[n] <= cnt[n] - 17'd1;
                    end
                end
            end
        end
    end

    // Outputs
    always_comb begin
        sm_restart = restart_q;
        exec_valid = pending;
        for (int unsigned n = 0; n < 4; n++) begin
            exec_instr [n*INSTR_W +: INSTR_W] = instr_r[n];
            wrap_top   [n*PC_W +: PC_W]       = wrap_top_r[n];
            wrap_bottom[n*PC_W +: PC_W]       = wrap_bot_r[n];
        end
    end

    // Host read mux
    always_comb begin
        rdata = '0;
        if (ctrl_sel) begin
            rdata[3:0] = enable;
        end else if (blk_hit) begin
            case (kind)
                REG_CLKDIV: begin
                    rdata[31:16] = div_int[sm_idx];
                    rdata[15:8]  = div_frac[sm_idx];
                end
                REG_EXECCTRL: begin
                    rdata[PC_W-1:0] = wrap_bot_r[sm_idx];
                    rdata[8 +: PC_W] = wrap_top_r[sm_idx];
                end
                REG_INSTR: begin
                    rdata[INSTR_W-1:0] = instr_r[sm_idx];
                    rdata[31]          = pending[sm_idx];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_ctrl.sv
// Scoreboard bench for sm_ctrl: stimulus pushes the expected per-cycle
// outputs from a behavioural model; a monitor pops and compares them.
module tb_sm_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [3:0]  sm_step, sm_restart, exec_valid;
    logic [63:0] exec_instr;
    logic [19:0] wrap_top, wrap_bottom;

    sm_ctrl #(.PC_W(5), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .sm_step(sm_step), .sm_restart(sm_restart),
        .exec_valid(exec_valid), .exec_instr(exec_instr),
        .wrap_top(wrap_top), .wrap_bottom(wrap_bottom)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  step;
        logic [3:0]  restart;
        logic [3:0]  valid;
        logic [31:0] rdata;
        logic [63:0] instr;
        logic [19:0] wtop;
        logic [19:0] wbot;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: integer state per SM
    int m_en[4], m_i[4], m_f[4], m_wb[4], m_wt[4], m_ins[4], m_pend[4], m_rs[4];
    int m_wait[4];   // cycles until the next step opportunity
    int m_phase[4];  // fractional phase in 1/256ths

    function automatic void model_reset();
        for (int n = 0; n < 4; n++) begin
            m_en[n] = 0; m_i[n] = 1; m_f[n] = 0; m_wb[n] = 0; m_wt[n] = 31;
            m_ins[n] = 0; m_pend[n] = 0; m_rs[n] = 0; m_wait[n] = 0; m_phase[n] = 0;
        end
    endfunction

    function automatic int model_step(int n);
        return (m_en[n] != 0 && m_wait[n] == 0 && m_rs[n] == 0) ? 1 : 0;
    endfunction

    function automatic logic [31:0] model_read(int a);
        logic [31:0] v = '0;
        if (a == 0) begin
            for (int n = 0; n < 4; n++) v[n] = (m_en[n] != 0);
        end else if (a >= 4 && a < 20) begin
            int n = (a - 4) / 4;
            int k = (a - 4) % 4;
            if (k == 0) v = 32'(m_i[n]) * 32'h10000 + 32'(m_f[n]) * 32'h100;
            else if (k == 1) v = 32'(m_wt[n]) * 32'h100 + 32'(m_wb[n]);
            else if (k == 2) v = (m_pend[n] != 0 ? 32'h8000_0000 : 32'h0) + 32'(m_ins[n]);
        end
        return v;
    endfunction

    function automatic exp_t model_out(int a);
        exp_t e;
        e.rdata = model_read(a);
        for (int n = 0; n < 4; n++) begin
            e.step[n]    = (model_step(n) != 0);
            e.restart[n] = (m_rs[n] != 0);
            e.valid[n]   = (m_pend[n] != 0);
            e.instr[n*16 +: 16] = 16'(m_ins[n]);
            e.wtop[n*5 +: 5] = 5'(m_wt[n]);
            e.wbot[n*5 +: 5] = 5'(m_wb[n]);
        end
        return e;
    endfunction

    function automatic void model_edge(logic we, int a, logic [31:0] d);
        int  stp[4];
        logic ctrl = we && (a == 0);
        for (int n = 0; n < 4; n++) stp[n] = model_step(n);
        for (int n = 0; n < 4; n++) begin
            // divider (uses the pre-edge enable and CLKDIV values)
            if (ctrl && d[8+n]) begin
                m_wait[n] = 0; m_phase[n] = 0;
            end else if (m_en[n] != 0) begin
                if (m_wait[n] == 0) begin
                    int per = (m_i[n] == 0) ? 65536 : m_i[n];
                    int extra = 0;
                    m_phase[n] += m_f[n];
                    if (m_phase[n] >= 256) begin m_phase[n] -= 256; extra = 1; end
                    m_wait[n] = per - 1 + extra;
                end else begin
                    m_wait[n]--;
                end
            end
            // forced instruction
            if (we && a == 4 + 4*n + 2) begin
                m_ins[n] = int'(d[15:0]); m_pend[n] = 1;
            end else if ((ctrl && d[4+n]) || stp[n] != 0) begin
                m_pend[n] = 0;
            end
            m_rs[n] = (ctrl && d[4+n]) ? 1 : 0;
            if (we && a == 4 + 4*n) begin
                m_i[n] = int'(d[31:16]); m_f[n] = int'(d[15:8]);
            end
            if (we && a == 4 + 4*n + 1) begin
                m_wb[n] = int'(d[4:0]); m_wt[n] = int'(d[12:8]);
            end
        end
        if (ctrl) for (int n = 0; n < 4; n++) m_en[n] = d[n] ? 1 : 0;
    endfunction

    // One cycle of stimulus: drive at negedge, queue expectation, advance model
    task automatic cyc(input logic we, input logic [4:0] a, input logic [31:0] d,
                       input logic r);
        @(negedge clk);
        rst = r; wr_en = we; addr = a; wdata = d;
        if (r) model_reset();
        sb.push_back(model_out(int'(a)));
        if (!r) model_edge(we, int'(a), d);
    endtask

    task automatic idle(input int cycles, input logic [4:0] a);
        for (int i = 0; i < cycles; i++) cyc(1'b0, a, 32'h0, 1'b0);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sm_step",     64'(sm_step),     64'(e.step));
                chk("sm_restart",  64'(sm_restart),  64'(e.restart));
                chk("exec_valid",  64'(exec_valid),  64'(e.valid));
                chk("rdata",       64'(rdata),       64'(e.rdata));
                chk("exec_instr",  exec_instr,       e.instr);
                chk("wrap_top",    64'(wrap_top),    64'(e.wtop));
                chk("wrap_bottom", 64'(wrap_bottom), 64'(e.wbot));
            end
        end
    end

    // Stimulus
    initial begin
        model_reset();
        cyc(1'b0, 5'd0, 32'h0, 1'b1);
        cyc(1'b0, 5'd0, 32'h0, 1'b1);

        // SM0 at reset divider: steps every cycle
        cyc(1'b1, 5'd0, 32'h1, 1'b0);
        idle(4, 5'd4);

        // int=3 frac=0x80 with divider restart: alternating 3/4 gaps
        cyc(1'b1, 5'd4, 32'h0003_8000, 1'b0);
        cyc(1'b1, 5'd0, 32'h0000_0101, 1'b0);
        idle(32, 5'd4);

        // back to every cycle, forced instr, then soft restart
        cyc(1'b1, 5'd4, 32'h0001_0000, 1'b0);
        idle(3, 5'd6);
        cyc(1'b1, 5'd6, 32'h0000_1234, 1'b0);
        cyc(1'b1, 5'd6, 32'h0000_5678, 1'b0);
        cyc(1'b1, 5'd0, 32'h0000_0011, 1'b0);
        idle(3, 5'd6);

        // SM2 disabled with pending instr, then enabled
        cyc(1'b1, 5'd14, 32'h0000_E021, 1'b0);
        idle(4, 5'd14);
        cyc(1'b1, 5'd0, 32'h0000_0005, 1'b0);
        idle(3, 5'd14);

        // wrap fields on SM3, then async reset
        cyc(1'b1, 5'd17, 32'h0000_1A05, 1'b0);
        idle(2, 5'd17);
        cyc(1'b0, 5'd0, 32'h0, 1'b1);
        idle(2, 5'd0);

        // SM1 int=0: period 65536
        cyc(1'b1, 5'd8, 32'h0000_0000, 1'b0);
        cyc(1'b1, 5'd0, 32'h0000_0202, 1'b0);
        idle(65540, 5'd8);

        // randomized register traffic
        for (int i = 0; i < 4000; i++) begin
            logic        we;
            logic [4:0]  a;
            logic [31:0] d;
            logic        r;
            we = ($urandom_range(0, 2) == 0);
            a  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) a = 5'(4 * $urandom_range(0, 4) + ($urandom_range(0, 5) % 3));
            d  = $urandom;
            if (we && a >= 5'd4 && a < 5'd20 && a[1:0] == 2'd0)
                d[31:16] = 16'($urandom_range(1, 4));
            if (we && a == 5'd0 && $urandom_range(0, 3) != 0)
                d[11:4] = '0;
            r = (i == 2000);
            cyc(we, a, d, r);
        end

        idle(1, 5'd0);
        @(negedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
